// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester, response and dmem buses of the two-port dmem arbiter.
//   rN_req/we/lock/addr/wdata : requester N access request and its fields
//   rN_gnt                    : request accepted this cycle (combinational)
//   rN_rvalid/rdata/err       : registered response one cycle after a grant
//   lock_abort                : pulse when a lock is force-released
//   mem_*                     : single-port dmem access (word-indexed address)
//   slave modport  : arbiter side
//   master modport : requesters plus memory side
interface dmem_arbiter_if;
    logic        r0_req;
    logic        r0_we;
    logic        r0_lock;
    logic [63:0] r0_addr;
    logic [63:0] r0_wdata;
    logic        r0_gnt;
    logic        r0_rvalid;
    logic [63:0] r0_rdata;
    logic        r0_err;
    logic        r1_req;
    logic        r1_we;
    logic        r1_lock;
    logic [63:0] r1_addr;
    logic [63:0] r1_wdata;
    logic        r1_gnt;
    logic        r1_rvalid;
    logic [63:0] r1_rdata;
    logic        r1_err;
    logic        lock_abort;
    logic [63:0] mem_address;
    logic [63:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [63:0] mem_read_data;
    modport slave (
        input  r0_req, r0_we, r0_lock, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_lock, r1_addr, r1_wdata,
        input  mem_read_data,
        output r0_gnt, r0_rvalid, r0_rdata, r0_err,
        output r1_gnt, r1_rvalid, r1_rdata, r1_err,
        output lock_abort, mem_address, mem_write_data, mem_write, mem_read
    );
    modport master (
        output r0_req, r0_we, r0_lock, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_lock, r1_addr, r1_wdata,
        output mem_read_data,
        input  r0_gnt, r0_rvalid, r0_rdata, r0_err,
        input  r1_gnt, r1_rvalid, r1_rdata, r1_err,
        input  lock_abort, mem_address, mem_write_data, mem_write, mem_read
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter with RMW lock in front of single-port dmem.
//   clk   : rising-edge clock
//   reset : synchronous active-low reset
//   bus   : dmem_arbiter_if.slave (requests, grants, responses, lock_abort, dmem port)
module dmem_arbiter #(
    parameter int DEPTH    = 1024,
    parameter int LOCK_MAX = 16
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    localparam int          CW       = $clog2(LOCK_MAX);
    localparam logic [CW-1:0] LAST_CNT = CW'(LOCK_MAX - 1);
    localparam logic [63:0] ADDR_LIM = 64'(DEPTH) << 3;
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    state_t        r_state;
    logic          r_last;
    logic [CW-1:0] r_lock_cnt;
    logic          r_rvalid0, r_rvalid1, r_err0, r_err1, r_abort;
    logic [63:0]   r_rdata0, r_rdata1;
    logic          w_req0, w_req1, w_gnt0, w_gnt1, w_gnt;
    logic          w_we, w_lock, w_legal, w_acc, w_expire;
    logic [63:0]   w_addr, w_wdata;
    always_comb begin
        w_req0   = reset & bus.r0_req;
        w_req1   = reset & bus.r1_req;
        // In IDLE a tie goes to the side that was not granted last.
        w_gnt0   = (r_state == OWN0) ? w_req0 : (r_state == OWN1) ? 1'b0 : w_req0 & (~w_req1 | r_last);
        w_gnt1   = (r_state == OWN1) ? w_req1 : (r_state == OWN0) ? 1'b0 : w_req1 & (~w_req0 | ~r_last);
        w_gnt    = w_gnt0 | w_gnt1;
        w_addr   = w_gnt1 ? bus.r1_addr  : bus.r0_addr;
        w_wdata  = w_gnt1 ? bus.r1_wdata : bus.r0_wdata;
        w_we     = w_gnt1 ? bus.r1_we    : bus.r0_we;
        w_lock   = w_gnt1 ? bus.r1_lock  : bus.r0_lock;
        w_legal  = (w_addr[2:0] == 3'b000) && (w_addr < ADDR_LIM);
        w_acc    = w_gnt & w_legal;
        // Only the owner can be granted while locked, so any grant here is the owner's.
        w_expire = (r_state != IDLE) && (r_lock_cnt == LAST_CNT) && !(w_gnt && !w_lock);
    end
    assign bus.r0_gnt         = w_gnt0;
    assign bus.r1_gnt         = w_gnt1;
    assign bus.mem_address    = w_acc ? {3'b000, w_addr[63:3]} : '0;
    assign bus.mem_write_data = w_acc ? w_wdata : '0;
    assign bus.mem_write      = w_acc & w_we;
    assign bus.mem_read       = w_acc & ~w_we;
    assign bus.r0_rvalid      = r_rvalid0;
    assign bus.r1_rvalid      = r_rvalid1;
    assign bus.r0_rdata       = r_rdata0;
    assign bus.r1_rdata       = r_rdata1;
    assign bus.r0_err         = r_err0;
    assign bus.r1_err         = r_err1;
    assign bus.lock_abort     = r_abort;
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_lock_cnt <= '0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
            r_err0     <= 1'b0;
            r_err1     <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_rvalid0  <= w_gnt0;
            r_rvalid1  <= w_gnt1;
            r_rdata0   <= (w_gnt0 & w_legal & ~w_we) ? bus.mem_read_data : '0;
            r_rdata1   <= (w_gnt1 & w_legal & ~w_we) ? bus.mem_read_data : '0;
            r_err0     <= w_gnt0 & ~w_legal;
            r_err1     <= w_gnt1 & ~w_legal;
            r_abort    <= w_expire;
            r_lock_cnt <= (r_state == IDLE) ? '0 : r_lock_cnt + CW'(1);
            if (w_gnt)
                r_last <= w_gnt1;
            // Forced release hands the next tie to the side that was locked out.
            if (w_expire) begin
                r_state <= IDLE;
                r_last  <= (r_state == OWN1);
            end else if (w_gnt) begin
                r_state <= w_lock ? (w_gnt1 ? OWN1 : OWN0) : IDLE;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a behavioural dmem.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   n_tot = 0;
    int   n_bad = 0;
    logic [63:0] mem [0:1023];
    dmem_arbiter_if bus ();
    dmem_arbiter #(.DEPTH(1024), .LOCK_MAX(16)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    assign bus.mem_read_data = mem[bus.mem_address[9:0]];
    always @(posedge clk)
        if (bus.mem_write) mem[bus.mem_address[9:0]] <= bus.mem_write_data;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle_reqs();
        bus.r0_req = 0; bus.r0_we = 0; bus.r0_lock = 0; bus.r0_addr = 0; bus.r0_wdata = 0;
        bus.r1_req = 0; bus.r1_we = 0; bus.r1_lock = 0; bus.r1_addr = 0; bus.r1_wdata = 0;
    endtask
    task automatic req0(input logic we, input logic lk, input logic [63:0] a, input logic [63:0] d);
        bus.r0_req = 1; bus.r0_we = we; bus.r0_lock = lk; bus.r0_addr = a; bus.r0_wdata = d;
    endtask
    task automatic req1(input logic we, input logic lk, input logic [63:0] a, input logic [63:0] d);
        bus.r1_req = 1; bus.r1_we = we; bus.r1_lock = lk; bus.r1_addr = a; bus.r1_wdata = d;
    endtask
    task automatic do_reset();
        reset = 0;
        idle_reqs();
        tick();
        tick();
        reset = 1;
    endtask
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] <= '0;
        mem[2] <= 64'hDEAD;
        mem[3] <= 64'hBEEF;
        reset = 0;
        idle_reqs();
        req0(0, 0, 64'h10, 0);
        tick();
        chk("rst_gnt0", bus.r0_gnt, 0);
        chk("rst_mrd", bus.mem_read, 0);
        tick();
        chk("rst_rv0", bus.r0_rvalid, 0);
        chk("rst_rv1", bus.r1_rvalid, 0);
        chk("rst_abort", bus.lock_abort, 0);
        chk("rst_rd0", bus.r0_rdata, 0);
        // basic load
        reset = 1;
        #1;
        chk("ld_gnt0", bus.r0_gnt, 1);
        chk("ld_mrd", bus.mem_read, 1);
        chk("ld_mwr", bus.mem_write, 0);
        chk("ld_maddr", bus.mem_address, 2);
        tick();
        bus.r0_req = 0;
        chk("ld_rv0", bus.r0_rvalid, 1);
        chk("ld_rd0", bus.r0_rdata, 64'hDEAD);
        chk("ld_err0", bus.r0_err, 0);
        chk("ld_rv1", bus.r1_rvalid, 0);
        // round robin
        do_reset();
        req0(0, 0, 64'h10, 0);
        req1(0, 0, 64'h18, 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_g0", bus.r0_gnt, 64'(i % 2 == 0));
            chk("rr_g1", bus.r1_gnt, 64'(i % 2 == 1));
            chk("rr_addr", bus.mem_address, (i % 2 == 0) ? 64'd2 : 64'd3);
            tick();
            chk("rr_v0", bus.r0_rvalid, 64'(i % 2 == 0));
            chk("rr_v1", bus.r1_rvalid, 64'(i % 2 == 1));
            chk("rr_d", (i % 2 == 0) ? bus.r0_rdata : bus.r1_rdata, (i % 2 == 0) ? 64'hDEAD : 64'hBEEF);
        end
        idle_reqs();
        // lock by r1, r0 stalls until release
        do_reset();
        req1(1, 1, 64'h40, 64'h1234);
        #1;
        chk("lk_g1", bus.r1_gnt, 1);
        chk("lk_mwr", bus.mem_write, 1);
        chk("lk_maddr", bus.mem_address, 8);
        chk("lk_mwd", bus.mem_write_data, 64'h1234);
        tick();
        chk("lk_rv1", bus.r1_rvalid, 1);
        chk("lk_rd1", bus.r1_rdata, 0);
        idle_reqs();
        req0(0, 0, 64'h40, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lk_stall0", bus.r0_gnt, 0);
            chk("lk_stall_mrd", bus.mem_read, 0);
            tick();
        end
        req1(0, 0, 64'h40, 0);
        #1;
        chk("lk_rel_g1", bus.r1_gnt, 1);
        chk("lk_rel_g0", bus.r0_gnt, 0);
        tick();
        bus.r1_req = 0;
        chk("lk_rel_rd1", bus.r1_rdata, 64'h1234);
        #1;
        chk("lk_after_g0", bus.r0_gnt, 1);
        tick();
        chk("lk_after_rv0", bus.r0_rvalid, 1);
        chk("lk_after_rd0", bus.r0_rdata, 64'h1234);
        idle_reqs();
        // forced lock release
        do_reset();
        req0(1, 1, 64'h20, 64'h55);
        req1(0, 0, 64'h10, 0);
        #1;
        chk("ab_g0", bus.r0_gnt, 1);
        chk("ab_g1", bus.r1_gnt, 0);
        tick();
        bus.r0_req = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("ab_stall1", bus.r1_gnt, 0);
            chk("ab_early", bus.lock_abort, 0);
            tick();
        end
        req0(0, 0, 64'h18, 0);
        #1;
        chk("ab_pulse", bus.lock_abort, 1);
        chk("ab_g1_win", bus.r1_gnt, 1);
        chk("ab_g0_lose", bus.r0_gnt, 0);
        tick();
        bus.r1_req = 0;
        chk("ab_pulse_end", bus.lock_abort, 0);
        chk("ab_rd1", bus.r1_rdata, 64'hDEAD);
        #1;
        chk("ab_then_g0", bus.r0_gnt, 1);
        tick();
        chk("ab_rd0", bus.r0_rdata, 64'hBEEF);
        chk("ab_mem4", mem[4], 64'h55);
        idle_reqs();
        // illegal accesses and address boundary
        do_reset();
        req0(1, 0, 64'h13, 64'hFF);
        #1;
        chk("mis_g0", bus.r0_gnt, 1);
        chk("mis_mwr", bus.mem_write, 0);
        chk("mis_mrd", bus.mem_read, 0);
        tick();
        chk("mis_rv0", bus.r0_rvalid, 1);
        chk("mis_err0", bus.r0_err, 1);
        chk("mis_rd0", bus.r0_rdata, 0);
        req0(1, 0, 64'h2000, 64'hFF);
        #1;
        chk("oor_g0", bus.r0_gnt, 1);
        chk("oor_mwr", bus.mem_write, 0);
        tick();
        chk("oor_err0", bus.r0_err, 1);
        chk("oor_rd0", bus.r0_rdata, 0);
        req0(0, 0, 64'h1FF8, 0);
        #1;
        chk("top_mrd", bus.mem_read, 1);
        chk("top_maddr", bus.mem_address, 64'h3FF);
        tick();
        chk("top_err0", bus.r0_err, 0);
        req0(0, 0, 64'h10, 0);
        tick();
        chk("mis_mem2", bus.r0_rdata, 64'hDEAD);
        chk("mis_mem0", mem[0], 0);
        idle_reqs();
        // reset during ownership
        do_reset();
        req0(1, 1, 64'h30, 64'h77);
        #1;
        chk("rl_g0", bus.r0_gnt, 1);
        tick();
        reset = 0;
        req0(0, 1, 64'h10, 0);
        #1;
        chk("rl_gforce", bus.r0_gnt, 0);
        chk("rl_mwr", bus.mem_write, 0);
        chk("rl_mrd", bus.mem_read, 0);
        tick();
        chk("rl_rv0", bus.r0_rvalid, 0);
        chk("rl_rv1", bus.r1_rvalid, 0);
        reset = 1;
        req0(0, 0, 64'h10, 0);
        req1(0, 0, 64'h18, 0);
        #1;
        chk("rl_tie0", bus.r0_gnt, 1);
        chk("rl_tie1", bus.r1_gnt, 0);
        tick();
        chk("rl_rd0", bus.r0_rdata, 64'hDEAD);
        bus.r0_req = 0;
        #1;
        chk("rl_g1", bus.r1_gnt, 1);
        tick();
        chk("rl_rd1", bus.r1_rdata, 64'hBEEF);
        idle_reqs();
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
